// File: rtl/eeprom_i2c_ctrl.sv
// -----------------------------------------------------------------------------
// eeprom_i2c_ctrl
//   Single-shot I2C master for a 24Cxx-style serial EEPROM. A rising edge on
//   GO_DB performs either a byte write or a random byte read at WORD_ADDR,
//   chosen by I2C_ADDR[0] (0 = write, 1 = read). One I2C bit period is 1024
//   CLK cycles, split into four quarters by CLK_COUNT[9:8].
//
// Ports
//   CLK          in    system clock, rising edge
//   RESET        in    asynchronous active-low reset
//   GO_DB        in    debounced start; a transaction starts on its rising edge
//   I2C_ADDR     in  8 control byte: [7:1] device address, [0] 1=read 0=write
//   WORD_ADDR    in  4 EEPROM word address, sent as {4'b0, WORD_ADDR}
//   EEPROM_DATA  io  8 write data in; read data out when I2C_ADDR[0]==1
//   I2C_SDAT     io    open-drain I2C data line
//   I2C_SCLK     out   I2C clock
//   CLK_COUNT    out 10 free-running bit-period divider
//   SD_COUNTER   out 6 transaction step index, 63 = idle
//
// Build option
//   ACK_CHECK_EN : when defined, a NACK seen at any ACK step skips straight to
//                  the STOP step of the current sequence.
// -----------------------------------------------------------------------------
module eeprom_i2c_ctrl (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       GO_DB,
  input  logic [7:0] I2C_ADDR,
  input  logic [3:0] WORD_ADDR,
  inout  wire  [7:0] EEPROM_DATA,
  inout  wire        I2C_SDAT,
  output logic       I2C_SCLK,
  output logic [9:0] CLK_COUNT,
  output logic [5:0] SD_COUNTER
);

  localparam logic [5:0] STEP_IDLE  = 6'd63;
  localparam logic [9:0] CNT_LAST   = 10'd1023;
  localparam logic [9:0] CNT_SAMPLE = 10'd768;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [9:0] r_clk_cnt;
  logic [5:0] r_step, w_step_nxt;
  logic       r_go_q;
  logic       r_rd;
  logic [7:0] r_wdata;
  logic [7:0] r_shift;
  logic [7:0] r_rdata;
  logic       r_scl;
  logic       r_sda_low;

  logic       w_tick;
  logic       w_sample;
  logic       w_go_rise;
  logic       w_arm;
  logic       w_sda_in;
  logic [1:0] w_q;
  logic [5:0] w_done_step;
  logic       w_is_ack;
  logic       w_rx_step;
  logic       w_scl;
  logic       w_sda_low;
  logic       w_tx_step;
  logic [7:0] w_tx_byte;
  logic [2:0] w_first;
  logic [2:0] w_bit_idx;

`ifdef ACK_CHECK_EN
  logic       r_nack;
  logic [5:0] w_stop_step;
`endif

  assign w_tick    = (r_clk_cnt == CNT_LAST);
  assign w_sample  = (r_clk_cnt == CNT_SAMPLE);
  assign w_go_rise = GO_DB & ~r_go_q;
  assign w_q       = r_clk_cnt[9:8];
  assign w_sda_in  = I2C_SDAT;

  assign w_done_step = r_rd ? 6'd39 : 6'd29;
  // ACK slots: 9 and 18 in both sequences, then 27 (write) or 28 (read).
  assign w_is_ack  = (r_step == 6'd9) || (r_step == 6'd18) ||
                     (r_rd ? (r_step == 6'd28) : (r_step == 6'd27));
  assign w_rx_step = r_rd && (r_step >= 6'd29) && (r_step <= 6'd36);

`ifdef ACK_CHECK_EN
  assign w_stop_step = r_rd ? 6'd38 : 6'd28;
`endif

  // Control state: idle -> armed on GO edge -> run from the next tick.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_arm       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_go_rise) begin
          w_state_nxt = ST_ARMED;
          w_arm       = 1'b1;
        end
      end
      ST_ARMED: begin
        if (w_tick) begin
          w_state_nxt = ST_RUN;
          w_step_nxt  = 6'd0;
        end
      end
      ST_RUN: begin
        if (w_tick) begin
          if (r_step == w_done_step) begin
            w_state_nxt = ST_IDLE;
            w_step_nxt  = STEP_IDLE;
          end
`ifdef ACK_CHECK_EN
          else if (r_nack) begin
            w_step_nxt = w_stop_step;
          end
`endif
          else begin
            w_step_nxt = r_step + 6'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_step_nxt  = STEP_IDLE;
      end
    endcase
  end

  // Bus waveform for the current step and quarter. Transmitted bytes go out
  // MSB first; w_first holds the low three bits of the byte's first step so
  // the bit index falls out of 3-bit modular arithmetic.
  always_comb begin
    w_scl     = 1'b1;
    w_sda_low = 1'b0;
    w_tx_step = 1'b0;
    w_tx_byte = 8'h00;
    w_first   = 3'd0;
    if (r_state == ST_RUN) begin
      if (r_step == 6'd0) begin
        // START: SDA falls while SCL is high
        w_sda_low = w_q[1];
      end else if (w_is_ack || w_rx_step || (r_rd && (r_step == 6'd37))) begin
        // slave-owned bit (ACK / read data) or master NACK: SDA released
        w_scl = w_q[1];
      end else if (r_step <= 6'd8) begin
        w_tx_step = 1'b1;
        w_tx_byte = {I2C_ADDR[7:1], 1'b0};
        w_first   = 3'd1;
      end else if (r_step <= 6'd17) begin
        w_tx_step = 1'b1;
        w_tx_byte = {4'b0000, WORD_ADDR};
        w_first   = 3'd2;
      end else if (!r_rd) begin
        if (r_step <= 6'd26) begin
          w_tx_step = 1'b1;
          w_tx_byte = r_wdata;
          w_first   = 3'd3;
        end else if (r_step == 6'd28) begin
          w_scl     = (w_q != 2'd0);
          w_sda_low = ~w_q[1];
        end
      end else begin
        if (r_step == 6'd19) begin
          // repeated START: SCL returns high before SDA falls
          w_scl     = (w_q != 2'd0);
          w_sda_low = w_q[1];
        end else if (r_step <= 6'd27) begin
          w_tx_step = 1'b1;
          w_tx_byte = {I2C_ADDR[7:1], 1'b1};
          w_first   = 3'd4;
        end else if (r_step == 6'd38) begin
          w_scl     = (w_q != 2'd0);
          w_sda_low = ~w_q[1];
        end
      end
    end
    w_bit_idx = 3'd7 - (r_step[2:0] - w_first);
    if (w_tx_step) begin
      w_scl     = w_q[1];
      w_sda_low = ~w_tx_byte[w_bit_idx];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_clk_cnt <= 10'd0;
      r_state   <= ST_IDLE;
      r_step    <= STEP_IDLE;
      r_go_q    <= 1'b0;
      r_rd      <= 1'b0;
      r_wdata   <= 8'h00;
      r_shift   <= 8'h00;
      r_rdata   <= 8'h00;
      r_scl     <= 1'b1;
      r_sda_low <= 1'b0;
    end else begin
      r_clk_cnt <= r_clk_cnt + 10'd1;
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_go_q    <= GO_DB;
      r_scl     <= w_scl;
      r_sda_low <= w_sda_low;
      if (w_arm) begin
        r_wdata <= EEPROM_DATA;
        r_rd    <= I2C_ADDR[0];
      end
      if (w_rx_step && w_sample) begin
        r_shift <= {r_shift[6:0], w_sda_in};
      end
      // the visible read register only changes once the whole byte is in
      if (w_rx_step && w_tick && (r_step == 6'd36)) begin
        r_rdata <= r_shift;
      end
    end
  end

`ifdef ACK_CHECK_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_nack <= 1'b0;
    end else if (w_tick) begin
      r_nack <= 1'b0;
    end else if ((r_state == ST_RUN) && w_is_ack && w_sample) begin
      r_nack <= w_sda_in;
    end
  end
`endif

  assign I2C_SCLK    = r_scl;
  assign I2C_SDAT    = r_sda_low ? 1'b0 : 1'bz;
  assign EEPROM_DATA = I2C_ADDR[0] ? r_rdata : 8'bzzzz_zzzz;
  assign CLK_COUNT   = r_clk_cnt;
  assign SD_COUNTER  = r_step;

endmodule

// File: tb/tb_eeprom_i2c_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eeprom_i2c_ctrl
//   Scoreboard bench for eeprom_i2c_ctrl. A transaction-level model expands
//   each requested transfer into the expected per-step SCL/SDA quarter levels
//   and queues them; a monitor samples the bus mid-quarter and pops one entry
//   per completed step. A simple slave ACKs and returns a byte on read.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eeprom_i2c_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic [7:0] i2c_addr = 8'hA1;
  logic [3:0] word_addr = 4'h0;
  wire  [7:0] eeprom_data;
  wire        sda;
  logic       scl;
  logic [9:0] clk_count;
  logic [5:0] sd_counter;

  logic       tb_drv = 1'b0;
  logic [7:0] tb_wdata = 8'h00;

  logic       slv_rd = 1'b0;
  logic [7:0] slv_byte = 8'h00;
  int         slv_nack_step = -1;
  logic       slv_low;

  always #5 clk = ~clk;

  assign eeprom_data = tb_drv ? tb_wdata : 8'bzzzz_zzzz;
  assign sda = slv_low ? 1'b0 : 1'bz;
  pullup (sda);

  eeprom_i2c_ctrl dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .GO_DB      (go),
    .I2C_ADDR   (i2c_addr),
    .WORD_ADDR  (word_addr),
    .EEPROM_DATA(eeprom_data),
    .I2C_SDAT   (sda),
    .I2C_SCLK   (scl),
    .CLK_COUNT  (clk_count),
    .SD_COUNTER (sd_counter)
  );

  // Slave: ACKs its slots (except a chosen one) and returns slv_byte MSB first.
  always_comb begin
    int s;
    s = int'(sd_counter);
    slv_low = 1'b0;
    if (s == 9 || s == 18 || (slv_rd ? (s == 28) : (s == 27))) begin
      slv_low = (s != slv_nack_step);
    end else if (slv_rd && s >= 29 && s <= 36) begin
      slv_low = ((slv_byte >> (36 - s)) & 8'h01) == 8'h00;
    end
  end

  typedef struct packed {
    logic [5:0] step;
    logic [3:0] scl;
    logic [3:0] sda;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   steps_seen = 0;
  int   m_step;
  int   m_limit;

  // ---------------- reference model ----------------
  // Bit q of scl4/sda4 is the line level in quarter q of the step.
  task automatic put(input logic [3:0] scl4, input logic [3:0] sda4);
    exp_t e;
    e.step = 6'(m_step);
    e.scl  = scl4;
    e.sda  = sda4;
    if (m_step < m_limit) exp_q.push_back(e);
    m_step++;
  endtask

  task automatic put_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) put(4'b1100, {4{b[i]}});
  endtask

  task automatic put_ack(input int nack_step, output bit abort);
    bit acked;
    acked = (m_step != nack_step);
    put(4'b1100, acked ? 4'b0000 : 4'b1111);
`ifdef ACK_CHECK_EN
    abort = !acked;
`else
    abort = 1'b0;
`endif
  endtask

  task automatic model_txn(input bit rd, input logic [6:0] dev, input logic [3:0] word,
                           input logic [7:0] wdata, input logic [7:0] rbyte,
                           input int nack_step, input int limit);
    bit ab;
    m_step  = 0;
    m_limit = limit;
    put(4'b1111, 4'b0011);                       // START
    put_byte({dev, 1'b0});
    put_ack(nack_step, ab);
    if (!ab) begin
      put_byte({4'b0000, word});
      put_ack(nack_step, ab);
    end
    if (!ab) begin
      if (!rd) begin
        put_byte(wdata);
        put_ack(nack_step, ab);
      end else begin
        put(4'b1110, 4'b0011);                   // repeated START
        put_byte({dev, 1'b1});
        put_ack(nack_step, ab);
        if (!ab) begin
          put_byte(rbyte);                       // slave-driven data
          put(4'b1100, 4'b1111);                 // master NACK
        end
      end
    end
    if (ab) m_step = rd ? 38 : 28;
    put(4'b1110, 4'b1100);                       // STOP
    put(4'b1111, 4'b1111);                       // done, bus idle
  endtask

  // ---------------- monitor ----------------
  logic [3:0] m_scl = 4'h0;
  logic [3:0] m_sda = 4'h0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && clk_count[7:0] == 8'd128) begin
      m_scl[clk_count[9:8]] = scl;
      m_sda[clk_count[9:8]] = sda;
    end
    if (rst_n && clk_count == 10'd960 && sd_counter != 6'd63) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL step_unexpected: got step %0d, required no activity", sd_counter);
      end else begin
        e = exp_q.pop_front();
        steps_seen++;
        if (sd_counter !== e.step || m_scl !== e.scl || m_sda !== e.sda) begin
          n_fail++;
          $display("FAIL step_%0d: got step=%0d scl=%b sda=%b, required step=%0d scl=%b sda=%b",
                   e.step, sd_counter, m_scl, m_sda, e.step, e.scl, e.sda);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic wait_step(input logic [5:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (sd_counter != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (sd_counter != s) begin
      n_fail++;
      $display("FAIL %s: got step %0d after %0d cycles, required step %0d", name, sd_counter, n, s);
    end
  endtask

  // Raise GO just before a tick so the transaction starts promptly.
  task automatic pulse_go_aligned();
    for (int i = 0; i < 1100 && clk_count != 10'd1000; i++) @(negedge clk);
    go = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          seen0;
    logic [6:0]  dev;
    logic [3:0]  wa;
    logic [7:0]  wd;

    rst_n    = 1'b0;
    go       = 1'b0;
    i2c_addr = 8'hA1;
    tb_drv   = 1'b0;
    #25;
    @(negedge clk);
    #1;
    check("rst_step", 32'(sd_counter), 32'd63);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_rdata", 32'(eeprom_data), 32'h00);
    check("rst_count", 32'(clk_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("count_1", 32'(clk_count), 32'd1);
    @(negedge clk); #1;
    check("count_2", 32'(clk_count), 32'd2);

    // Random write, slave NACKs the control byte; reset lands in step 12.
    dev           = 7'($urandom_range(0, 127));
    wa            = 4'($urandom_range(0, 15));
    wd            = 8'($urandom_range(0, 255));
    i2c_addr      = {dev, 1'b0};
    word_addr     = wa;
    tb_wdata      = wd;
    tb_drv        = 1'b1;
    slv_rd        = 1'b0;
    slv_nack_step = 9;
`ifdef ACK_CHECK_EN
    model_txn(1'b0, dev, wa, wd, 8'h00, 9, 64);
`else
    model_txn(1'b0, dev, wa, wd, 8'h00, 9, 12);
`endif
    seen0 = steps_seen;
    pulse_go_aligned();
    wait_step(6'd0, 1100, "abort_start");
`ifdef ACK_CHECK_EN
    wait_step(6'd63, 32 * 1024, "nack_idle");
    check("nack_steps", 32'(steps_seen - seen0), 32'd12);
    go = 1'b0;
`else
    wait_step(6'd12, 13 * 1024, "abort_step12");
    repeat ($urandom_range(0, 800)) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_step", 32'(sd_counter), 32'd63);
    check("abort_scl", 32'(scl), 32'd1);
    check("abort_sda", 32'(sda), 32'd1);
    check("abort_steps", 32'(steps_seen - seen0), 32'd12);
    go = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);

    // Write 0x55 to word 3 of device 0x50; GO stays high afterwards.
    slv_nack_step = -1;
    i2c_addr      = 8'hA0;
    word_addr     = 4'h3;
    tb_wdata      = 8'h55;
    model_txn(1'b0, 7'h50, 4'h3, 8'h55, 8'h00, -1, 64);
    seen0 = steps_seen;
    pulse_go_aligned();
    wait_step(6'd0, 1100, "wr_start");
    wait_step(6'd63, 31 * 1024, "wr_idle");
    check("wr_steps", 32'(steps_seen - seen0), 32'd30);
    check("wr_queue", 32'(exp_q.size()), 32'd0);
    repeat (1200) @(negedge clk);
    #1;
    check("go_held_idle", 32'(sd_counter), 32'd63);
    check("go_held_steps", 32'(steps_seen - seen0), 32'd30);

    // Random read of word 0; slave returns 0xC3.
    go        = 1'b0;
    tb_drv    = 1'b0;
    i2c_addr  = 8'hA1;
    word_addr = 4'h0;
    slv_rd    = 1'b1;
    slv_byte  = 8'hC3;
    repeat (4) @(negedge clk);
    model_txn(1'b1, 7'h50, 4'h0, 8'h00, 8'hC3, -1, 64);
    seen0 = steps_seen;
    pulse_go_aligned();
    wait_step(6'd0, 1100, "rd_start");
    wait_step(6'd36, 37 * 1024, "rd_step36");
    #1 check("rd_data_step36", 32'(eeprom_data), 32'h00);
    wait_step(6'd37, 1100, "rd_step37");
    #1 check("rd_data_after", 32'(eeprom_data), 32'hC3);
    wait_step(6'd63, 3 * 1024, "rd_idle");
    check("rd_steps", 32'(steps_seen - seen0), 32'd40);
    check("rd_queue", 32'(exp_q.size()), 32'd0);
    #1;
    check("idle_scl", 32'(scl), 32'd1);
    check("idle_sda", 32'(sda), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
